fp_sum_tree_acc: RTL and testbench

- Parametrised successor of the fixed 8-input FP32 sum stage in the convolution datapath.
- Sums NUM_IN IEEE-754 single-precision operands per beat with a registered fp_adder tree.
- Accumulates a runtime-programmable number of beats per output (input-channel groups), adds a per-group bias and optionally applies ReLU.
- Emits each result with frame markers (o_sof/o_eof) to the downstream writer.

---
 rtl/fp_sum_tree_acc.sv | 226 ++++++++++++++++++++++
 tb/tb_fp_sum_tree_acc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sum_tree_acc.sv
`default_nettype none
// ============================================================================
// fp_sum_tree_acc : registered FP32 adder tree, per-group accumulation,
//                   bias, optional ReLU and frame markers.
// Revision        : 1.0
// ============================================================================
module fp_sum_tree_acc #(
    parameter int NUM_IN    = 8,
    parameter int ACC_LEN_W = 16,
    parameter int FRAME_W   = 4,
    parameter int FRAME_H   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [NUM_IN*32-1:0]   i_data,
    input  logic [ACC_LEN_W-1:0]   i_acc_len,
    input  logic [31:0]            i_bias,
    input  logic                   i_relu_en,
    input  logic                   i_flush,
    output logic                   o_valid,
    output logic [31:0]            o_data,
    output logic                   o_sof,
    output logic                   o_eof
);

    localparam int c_lvl   = $clog2(NUM_IN);
    localparam int c_nodes = 2 * NUM_IN - 1;
    localparam int c_col_w = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int c_row_w = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    typedef struct packed {
        logic        first;
        logic        last;
        logic        relu;
        logic [31:0] bias;
    } sb_t;

    // IEEE-754 binary32 add, round-to-nearest-even, subnormals supported.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  ex, ey, d, e_base;
        logic [23:0] mx, my;
        logic [49:0] by_full;
        logic [50:0] ax, by_sh, s, n;
        logic        st, rnd;
        logic [30:0] mag;
        int          p, er, k;
        if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]) ||
            (&a[30:23] && &b[30:23] && (a[31] ^ b[31])))
            return 32'h7FC0_0000;
        if (&a[30:23]) return a;
        if (&b[30:23]) return b;
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex      = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey      = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx      = {|x[30:23], x[22:0]};
        my      = {|y[30:23], y[22:0]};
        d       = ex - ey;
        ax      = {1'b0, mx, 26'd0};
        by_full = {my, 26'd0};
        // Bits shifted past the datapath collapse into a sticky LSB.
        if (d > 8'd49) begin
            by_sh = 51'd0;
            st    = |my;
        end else begin
            by_sh = {1'b0, by_full >> d};
            st    = |(by_full & ((50'd1 << d) - 50'd1));
        end
        by_sh = by_sh | {50'd0, st};
        s     = (x[31] == y[31]) ? (ax + by_sh) : (ax - by_sh);
        if (s == 51'd0)
            return {x[31] & y[31], 31'd0};
        p = 0;
        for (int q = 0; q < 51; q++)
            if (s[q]) p = q;
        er = int'(ex) + p - 49;
        if (er >= 255)
            return {x[31], 8'hFF, 23'd0};
        k      = (er >= 1) ? (50 - p) : int'(ex);
        n      = s << k;
        rnd    = n[26] & ((|n[25:0]) | n[27]);
        e_base = (er >= 1) ? 8'(er - 1) : 8'd0;
        mag    = {e_base, 23'd0} + {7'd0, n[50:27]} + {30'd0, rnd};
        return {x[31], mag};
    endfunction

    // ---------------- input stage ----------------
    logic [ACC_LEN_W-1:0] cnt_q, cnt_d, len_q, w_len_in, w_len;
    logic [31:0]          bias_q;
    logic                 relu_q, w_first, w_last;
    sb_t                  w_sb_in;

    always_comb begin
        w_first  = (cnt_q == '0);
        w_len_in = (i_acc_len == '0) ? ACC_LEN_W'(1) : i_acc_len;
        w_len    = w_first ? w_len_in : len_q;
        w_last   = (cnt_q == (w_len - ACC_LEN_W'(1)));
        cnt_d    = cnt_q;
        if (i_valid)
            cnt_d = w_last ? '0 : (cnt_q + ACC_LEN_W'(1));
        w_sb_in.first = w_first;
        w_sb_in.last  = w_last;
        w_sb_in.relu  = w_first ? i_relu_en : relu_q;
        w_sb_in.bias  = w_first ? i_bias : bias_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            len_q  <= '0;
            bias_q <= '0;
            relu_q <= 1'b0;
        end else if (i_flush) begin
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_valid && w_first) begin
                len_q  <= w_len_in;
                bias_q <= i_bias;
                relu_q <= i_relu_en;
            end
        end
    end

    // ---------------- tree pipeline ----------------
    // Node layout: leaves at 0..NUM_IN-1, children of node i are 2i-2N and 2i-2N+1.
    logic [31:0] node_q [0:c_nodes-1];
    sb_t         sb_q   [0:c_lvl];
    logic [c_lvl:0] vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_nodes; i++) node_q[i] <= '0;
            for (int l = 0; l <= c_lvl; l++) sb_q[l]    <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) node_q[i] <= i_data[32*i +: 32];
            for (int i = NUM_IN; i < c_nodes; i++)
                node_q[i] <= fp_add(node_q[2*i-2*NUM_IN], node_q[2*i-2*NUM_IN+1]);
            sb_q[0] <= w_sb_in;
            for (int l = 1; l <= c_lvl; l++) sb_q[l] <= sb_q[l-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          vld_q <= '0;
        else if (i_flush) vld_q <= '0;
        else              vld_q <= {vld_q[c_lvl-1:0], i_valid};
    end

    // ---------------- accumulate and output stages ----------------
    logic [31:0] acc_q, acc_bias_q, o_data_q, w_res;
    logic        acc_last_q, acc_relu_q, o_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            acc_bias_q <= '0;
            acc_relu_q <= 1'b0;
            acc_last_q <= 1'b0;
        end else if (i_flush) begin
            acc_last_q <= 1'b0;
        end else begin
            acc_last_q <= vld_q[c_lvl] && sb_q[c_lvl].last;
            if (vld_q[c_lvl]) begin
                acc_q      <= sb_q[c_lvl].first ? node_q[c_nodes-1]
                                                : fp_add(acc_q, node_q[c_nodes-1]);
                acc_bias_q <= sb_q[c_lvl].bias;
                acc_relu_q <= sb_q[c_lvl].relu;
            end
        end
    end

    assign w_res = fp_add(acc_q, acc_bias_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else if (i_flush) begin
            o_valid_q <= 1'b0;
        end else begin
            o_valid_q <= acc_last_q;
            if (acc_last_q)
                o_data_q <= (acc_relu_q && w_res[31]) ? 32'h0 : w_res;
        end
    end

    // ---------------- frame counters ----------------
    logic [c_col_w-1:0] col_q, col_d;
    logic [c_row_w-1:0] row_q, row_d;
    logic               w_col_end, w_row_end;

    always_comb begin
        w_col_end = (col_q == c_col_w'(FRAME_W - 1));
        w_row_end = (row_q == c_row_w'(FRAME_H - 1));
        col_d     = col_q;
        row_d     = row_q;
        if (o_valid_q) begin
            col_d = w_col_end ? '0 : (col_q + c_col_w'(1));
            if (w_col_end)
                row_d = w_row_end ? '0 : (row_q + c_row_w'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_flush) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sof   = o_valid_q && (col_q == '0) && (row_q == '0);
    assign o_eof   = o_valid_q && w_col_end && w_row_end;

endmodule
`default_nettype wire

// File: tb/tb_fp_sum_tree_acc.sv
`default_nettype none
// ============================================================================
// tb_fp_sum_tree_acc : table vectors, corner sequences and random groups
//                      checked against a real-arithmetic reference model.
// Revision           : 1.0
// ============================================================================
module tb_fp_sum_tree_acc;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid, i_relu_en, i_flush;
    logic [N*32-1:0] i_data;
    logic [15:0]    i_acc_len;
    logic [31:0]    i_bias;
    logic           o_valid, o_sof, o_eof;
    logic [31:0]    o_data;

    fp_sum_tree_acc #(.NUM_IN(N), .ACC_LEN_W(16), .FRAME_W(2), .FRAME_H(2)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .i_acc_len(i_acc_len), .i_bias(i_bias), .i_relu_en(i_relu_en),
        .i_flush(i_flush), .o_valid(o_valid), .o_data(o_data),
        .o_sof(o_sof), .o_eof(o_eof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] op;
        int          len;
        logic [31:0] bias;
        logic        relu;
        logic [31:0] exp_data;
    } vec_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_vec = 0, n_err = 0;
    int          m_cnt = 0, m_len = 1, m_idx = 0;
    logic [31:0] m_acc, m_bias;
    logic        m_relu;

    // Exact float -> double (normal numbers and zeros only).
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e11;
        if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
        e11 = {3'b0, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'd0});
    endfunction

    // Double -> float, round to nearest even.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [30:0] mag;
        int          e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e   = int'(b[62:52]) - 896;
        mag = {8'(e), b[51:29]} + 31'(b[28] & ((|b[27:0]) | b[29]));
        return {b[63], mag};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] tree_sum(input logic [N*32-1:0] d);
        logic [31:0] v [N];
        for (int k = 0; k < N; k++) v[k] = d[32*k +: 32];
        for (int w = N; w > 1; w = w / 2)
            for (int j = 0; j < w / 2; j++) v[j] = fadd(v[2*j], v[2*j+1]);
        return v[0];
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one beat and updates the reference model; the expectation of a
    // completed group is the model's unless a fixed table value is supplied.
    task automatic beat(input logic [N*32-1:0] d, input int len, input logic [31:0] bias,
                        input logic relu, input logic has_exp, input logic [31:0] xexp);
        logic [31:0] t, r;
        i_valid = 1'b1; i_data = d; i_acc_len = 16'(len);
        i_bias = bias; i_relu_en = relu; i_flush = 1'b0;
        t = tree_sum(d);
        if (m_cnt == 0) begin
            m_len = (len == 0) ? 1 : len;
            m_bias = bias; m_relu = relu; m_acc = t;
        end else begin
            m_acc = fadd(m_acc, t);
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            r = fadd(m_acc, m_bias);
            if (m_relu && r[31]) r = 32'h0;
            if (has_exp) r = xexp;
            q.push_back('{r, (m_idx % 4) == 0, (m_idx % 4) == 3, cyc + 6});
            m_idx++;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic flush_now();
        i_flush = 1'b1; i_valid = 1'b1; i_data = {N{32'h3F80_0000}};
        for (int j = q.size() - 1; j >= 0; j--)
            if (q[j].due >= cyc + 1) q.delete(j);
        m_cnt = 0; m_idx = 0;
        @(posedge clk);
        #1;
        i_flush = 1'b0; i_valid = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{32'h3F80_0000, 1, 32'h0,         1'b0, 32'h4100_0000};
        vecs[1] = '{32'h3F80_0000, 3, 32'h3F80_0000, 1'b0, 32'h41C8_0000};
        vecs[2] = '{32'hBF80_0000, 1, 32'h0,         1'b1, 32'h0000_0000};
        vecs[3] = '{32'hBF80_0000, 1, 32'h0,         1'b0, 32'hC100_0000};
        vecs[4] = '{32'hBF80_0000, 1, 32'h0,         1'b1, 32'h0000_0000};
        vecs[5] = '{32'h3F00_0000, 2, 32'hBF80_0000, 1'b0, 32'h40E0_0000};
        vecs[6] = '{32'h4000_0000, 0, 32'h0,         1'b0, 32'h4180_0000};
        vecs[7] = '{32'hBE80_0000, 1, 32'h3F80_0000, 1'b1, 32'h0000_0000};
        vecs[8] = '{32'h3F80_0000, 1, 32'hBF80_0000, 1'b1, 32'h40E0_0000};
        vecs[9] = '{32'h3F80_0000, 1, 32'hC100_0000, 1'b0, 32'h0000_0000};

        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_acc_len = 16'd1;
        i_bias = 32'h0; i_relu_en = 1'b0; i_flush = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (o_valid) begin
                        n_vec++;
                        if (q.size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_output cyc=%0d data=%h", cyc, o_data);
                        end else begin
                            mon_e = q.pop_front();
                            if (o_data !== mon_e.data || o_sof !== mon_e.sof ||
                                o_eof !== mon_e.eof || cyc != mon_e.due) begin
                                n_err++;
                                $display("FAIL output cyc=%0d got data=%h sof=%b eof=%b, want data=%h sof=%b eof=%b cyc=%0d",
                                         cyc, o_data, o_sof, o_eof, mon_e.data, mon_e.sof, mon_e.eof, mon_e.due);
                            end
                        end
                    end else if (q.size() != 0 && q[0].due <= cyc) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL missing_output cyc=%0d want data=%h due=%0d", cyc, q[0].data, q[0].due);
                        void'(q.pop_front());
                    end
                end
            end
        join_none

        @(posedge clk);
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_data !== 32'h0 || o_sof !== 1'b0 || o_eof !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got v=%b d=%h s=%b e=%b, want all zero", o_valid, o_data, o_sof, o_eof);
        end
        idle(2);
        rst = 1'b0;

        // Table vectors, applied back to back.
        for (int v = 0; v < 10; v++)
            for (int b = 0; b < ((vecs[v].len == 0) ? 1 : vecs[v].len); b++)
                beat({N{vecs[v].op}}, vecs[v].len, vecs[v].bias, vecs[v].relu, 1'b1, vecs[v].exp_data);
        idle(8);

        // Gaps inside a group; the later beats carry a different configuration.
        beat({N{32'h3F80_0000}}, 3, 32'h3F80_0000, 1'b0, 1'b1, 32'h41C8_0000);
        idle(2);
        beat({N{32'h3F80_0000}}, 7, 32'hC000_0000, 1'b1, 1'b1, 32'h41C8_0000);
        idle(2);
        beat({N{32'h3F80_0000}}, 1, 32'h4000_0000, 1'b1, 1'b1, 32'h41C8_0000);
        idle(8);

        // Five groups from a clean frame: sof on 1st and 5th, eof on 4th.
        flush_now();
        for (int g = 0; g < 5; g++)
            beat({N{32'h3F80_0000}}, 1, 32'h0, 1'b0, 1'b1, 32'h4100_0000);
        idle(8);

        // Flush in the middle of a group, then a fresh group.
        beat({N{32'h3F80_0000}}, 4, 32'h0, 1'b0, 1'b0, 32'h0);
        beat({N{32'h3F80_0000}}, 4, 32'h0, 1'b0, 1'b0, 32'h0);
        flush_now();
        beat({N{32'h3F80_0000}}, 1, 32'h0, 1'b0, 1'b1, 32'h4100_0000);
        idle(8);

        // Random groups with random gaps and mid-group configuration noise.
        for (int g = 0; g < 40; g++) begin
            int          len;
            logic [31:0] gb;
            logic        gr;
            logic [N*32-1:0] d;
            len = $urandom_range(1, 4);
            gb  = ($urandom_range(0, 3) == 0) ? 32'h0 : rand_fp();
            gr  = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                for (int k = 0; k < N; k++) d[32*k +: 32] = rand_fp();
                if (b == 0) beat(d, len, gb, gr, 1'b0, 32'h0);
                else        beat(d, $urandom_range(0, 7), rand_fp(), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(8);

        // Asynchronous reset while a result is on the outputs and a group is open.
        beat({N{32'h3F80_0000}}, 1, 32'h0, 1'b0, 1'b1, 32'h4100_0000);
        beat({N{32'h3F80_0000}}, 2, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(4);
        rst = 1'b1;
        q.delete();
        m_cnt = 0; m_idx = 0;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_data !== 32'h0 || o_sof !== 1'b0 || o_eof !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got v=%b d=%h s=%b e=%b, want all zero", o_valid, o_data, o_sof, o_eof);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat({N{32'h3F80_0000}}, 1, 32'h0, 1'b0, 1'b1, 32'h4100_0000);
        idle(10);

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending results, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
